// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stage stall requests and sequences trap/mret flushes.
// Optional LSU stall watchdog is built when PIPE_CTRL_WDT_EN is defined.
module pipe_ctrl #(
    parameter int unsigned WDT_LIMIT = 1024
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        branch_redirect_i,
    input  logic [31:0] branch_target_i,
    input  logic        trap_req_i,
    input  logic [31:0] trap_vector_i,
    input  logic        mret_req_i,
    input  logic [31:0] mepc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        RUN,
        TRAP_WAIT,
        FLUSH
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [5:0]  stall_run;
    logic [5:0]  stall_c;
    logic        redirect_c;
    logic [31:0] redirect_pc_c;
    logic        commit_req;

    assign commit_req = trap_req_i | mret_req_i;

    // Each stall freezes its own stage and everything upstream; WB never stops.
    always_comb begin
        stall_run = 6'b000000;
        if (stallreq_mem_i)      stall_run = 6'b011111;
        else if (stallreq_ex_i)  stall_run = 6'b001111;
        else if (stallreq_id_i)  stall_run = 6'b000111;
        else if (stallreq_if_i)  stall_run = 6'b000011;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        stall_c       = 6'b000000;
        redirect_c    = 1'b0;
        redirect_pc_c = 32'h0;
        unique case (state_q)
            RUN: begin
                stall_c = stall_run;
                if (commit_req) begin
                    pc_d    = trap_req_i ? trap_vector_i : mepc_i;
                    state_d = stallreq_mem_i ? TRAP_WAIT : FLUSH;
                end else if (branch_redirect_i && !stall_run[3]) begin
                    redirect_c    = 1'b1;
                    redirect_pc_c = branch_target_i;
                end
            end
            TRAP_WAIT: begin
                stall_c = 6'b011111;
                if (!stallreq_mem_i) state_d = FLUSH;
            end
            FLUSH: begin
                redirect_c    = 1'b1;
                redirect_pc_c = pc_q;
                state_d       = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= RUN;
            pc_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Combinational outputs are forced low while reset is held, not just after the next edge.
    assign stall_o       = n_rst_i ? stall_c       : 6'b000000;
    assign redirect_o    = n_rst_i ? redirect_c    : 1'b0;
    assign redirect_pc_o = n_rst_i ? redirect_pc_c : 32'h0;
    assign flush_o       = (state_q == FLUSH);

`ifdef PIPE_CTRL_WDT_EN
    localparam logic [15:0] WDT_MAX = 16'(WDT_LIMIT);

    logic [15:0] wdt_q;
    logic        timeout_q;

    // Saturates at the limit so the pulse fires once per uninterrupted stall run.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            wdt_q     <= 16'h0;
            timeout_q <= 1'b0;
        end else if (stallreq_mem_i) begin
            if (wdt_q != WDT_MAX) wdt_q <= wdt_q + 16'd1;
            timeout_q <= (wdt_q == WDT_MAX - 16'd1);
        end else begin
            wdt_q     <= 16'h0;
            timeout_q <= 1'b0;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed test-plan sequences plus random
// stimulus, all compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int LIM = 4;
`ifdef PIPE_CTRL_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        n_rst_i;
    logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
    logic        branch_redirect_i;
    logic [31:0] branch_target_i;
    logic        trap_req_i;
    logic [31:0] trap_vector_i;
    logic        mret_req_i;
    logic [31:0] mepc_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        timeout_o;

    always #5 clk_i = ~clk_i;

    pipe_ctrl #(.WDT_LIMIT(LIM)) dut (
        .clk_i             (clk_i),
        .n_rst_i           (n_rst_i),
        .stallreq_if_i     (stallreq_if_i),
        .stallreq_id_i     (stallreq_id_i),
        .stallreq_ex_i     (stallreq_ex_i),
        .stallreq_mem_i    (stallreq_mem_i),
        .branch_redirect_i (branch_redirect_i),
        .branch_target_i   (branch_target_i),
        .trap_req_i        (trap_req_i),
        .trap_vector_i     (trap_vector_i),
        .mret_req_i        (mret_req_i),
        .mepc_i            (mepc_i),
        .stall_o           (stall_o),
        .flush_o           (flush_o),
        .redirect_o        (redirect_o),
        .redirect_pc_o     (redirect_pc_o),
        .timeout_o         (timeout_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: a pending trap is either waiting for the LSU or due to flush now.
    bit          m_waiting;
    bit          m_flush_now;
    logic [31:0] m_target;
    int          m_mem_run;
    bit          m_timeout;
    int          pulses;

    task automatic model_reset();
        m_waiting   = 1'b0;
        m_flush_now = 1'b0;
        m_target    = 32'h0;
        m_mem_run   = 0;
        m_timeout   = 1'b0;
    endtask

    function automatic logic [5:0] priority_stall();
        int depth;
        if (stallreq_mem_i)     depth = 5;
        else if (stallreq_ex_i) depth = 4;
        else if (stallreq_id_i) depth = 3;
        else if (stallreq_if_i) depth = 2;
        else                    depth = 0;
        return 6'((1 << depth) - 1);
    endfunction

    task automatic idle();
        stallreq_if_i     = 1'b0;
        stallreq_id_i     = 1'b0;
        stallreq_ex_i     = 1'b0;
        stallreq_mem_i    = 1'b0;
        branch_redirect_i = 1'b0;
        branch_target_i   = 32'h0;
        trap_req_i        = 1'b0;
        trap_vector_i     = 32'h0;
        mret_req_i        = 1'b0;
        mepc_i            = 32'h0;
    endtask

    // Check one cycle mid-period, then advance the model across the clock edge.
    task automatic step();
        logic [5:0]  e_stall;
        logic        e_flush, e_red;
        logic [31:0] e_pc;
        #2;
        if (m_flush_now) begin
            e_stall = 6'b0; e_flush = 1'b1; e_red = 1'b1; e_pc = m_target;
        end else if (m_waiting) begin
            e_stall = 6'b011111; e_flush = 1'b0; e_red = 1'b0; e_pc = 32'h0;
        end else begin
            e_stall = priority_stall();
            e_flush = 1'b0;
            e_red   = branch_redirect_i && !trap_req_i && !mret_req_i
                      && !stallreq_mem_i && !stallreq_ex_i;
            e_pc    = e_red ? branch_target_i : 32'h0;
        end
        check("stall", 32'(stall_o), 32'(e_stall));
        check("flush", 32'(flush_o), 32'(e_flush));
        check("redirect", 32'(redirect_o), 32'(e_red));
        check("redirect_pc", redirect_pc_o, e_pc);
        check("timeout", 32'(timeout_o), 32'(m_timeout));
        if (timeout_o) pulses++;
        @(posedge clk_i);
        if (stallreq_mem_i) begin
            m_timeout = WDT_ON && (m_mem_run == LIM - 1);
            if (m_mem_run < LIM) m_mem_run++;
        end else begin
            m_timeout = 1'b0;
            m_mem_run = 0;
        end
        if (m_flush_now) begin
            m_flush_now = 1'b0;
        end else if (m_waiting) begin
            if (!stallreq_mem_i) begin
                m_waiting   = 1'b0;
                m_flush_now = 1'b1;
            end
        end else if (trap_req_i || mret_req_i) begin
            m_target = trap_req_i ? trap_vector_i : mepc_i;
            if (stallreq_mem_i) m_waiting = 1'b1;
            else                m_flush_now = 1'b1;
        end
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        pulses  = 0;
        n_rst_i = 1'b0;
        #3;
        check("reset_stall", 32'(stall_o), 32'h0);
        check("reset_flush", 32'(flush_o), 32'h0);
        check("reset_timeout", 32'(timeout_o), 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        n_rst_i = 1'b1;

        // Stall priority.
        stallreq_if_i = 1'b1; stallreq_ex_i = 1'b1; step();
        stallreq_mem_i = 1'b1; step();
        idle(); step();

        // Branch, then the same branch blocked by an EX stall.
        branch_redirect_i = 1'b1; branch_target_i = 32'h0000_0120; step();
        stallreq_ex_i = 1'b1; step();
        idle(); step();

        // Trap and mret together with no LSU stall.
        trap_req_i = 1'b1; mret_req_i = 1'b1;
        trap_vector_i = 32'h8000_0004; mepc_i = 32'h0000_0200; step();
        idle(); step();
        step();

        // Trap during an LSU stall, with a branch pulse in cycle 3.
        trap_req_i = 1'b1; trap_vector_i = 32'h8000_0010; stallreq_mem_i = 1'b1; step();
        idle();
        for (int c = 1; c <= 5; c++) begin
            stallreq_mem_i    = (c <= 4);
            branch_redirect_i = (c == 3);
            branch_target_i   = 32'h0000_0400;
            trap_req_i        = (c == 2);
            trap_vector_i     = 32'hdead_0000;
            step();
        end
        idle(); step();
        step();

        // Mret latching mepc, and a trap raised in the flush cycle is lost.
        mret_req_i = 1'b1; mepc_i = 32'h0000_0abc; step();
        idle(); trap_req_i = 1'b1; trap_vector_i = 32'h1234_5678; step();
        idle(); step();

        // Watchdog: ten high cycles, one low, four high.
        pulses = 0;
        stallreq_mem_i = 1'b1; repeat (10) step();
        stallreq_mem_i = 1'b0; step();
        stallreq_mem_i = 1'b1; repeat (4) step();
        stallreq_mem_i = 1'b0; repeat (2) step();
        check("wdt_pulse_count", 32'(pulses), WDT_ON ? 32'd2 : 32'd0);

        // Reset asserted mid-TRAP_WAIT.
        trap_req_i = 1'b1; trap_vector_i = 32'h0000_0800; stallreq_mem_i = 1'b1; step();
        trap_req_i = 1'b0; stallreq_ex_i = 1'b1; branch_redirect_i = 1'b1; step();
        #2;
        n_rst_i = 1'b0;
        #1;
        check("rst_async_stall", 32'(stall_o), 32'h0);
        check("rst_async_flush", 32'(flush_o), 32'h0);
        check("rst_async_redirect", 32'(redirect_o), 32'h0);
        check("rst_async_pc", redirect_pc_o, 32'h0);
        check("rst_async_timeout", 32'(timeout_o), 32'h0);
        idle();
        model_reset();
        @(posedge clk_i);
        #1;
        n_rst_i = 1'b1;
        repeat (3) step();

        // Randomized traffic with sticky LSU stalls.
        for (int i = 0; i < 3000; i++) begin
            if (stallreq_mem_i) stallreq_mem_i = ($urandom_range(0, 9) < 7);
            else                stallreq_mem_i = ($urandom_range(0, 9) < 2);
            stallreq_if_i     = ($urandom_range(0, 3) == 0);
            stallreq_id_i     = ($urandom_range(0, 4) == 0);
            stallreq_ex_i     = ($urandom_range(0, 4) == 0);
            branch_redirect_i = ($urandom_range(0, 2) == 0);
            branch_target_i   = $urandom;
            trap_req_i        = ($urandom_range(0, 9) == 0);
            trap_vector_i     = $urandom;
            mret_req_i        = ($urandom_range(0, 9) == 0);
            mepc_i            = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage core. It merges per-stage stall requests into the `stall_o[5:0]` vector consumed by every pipeline register, including the EX/MEM register, and sequences trap/mret pipeline flushes. It holds a trap until an outstanding LSU access completes, then drives a one-cycle `flush_o` with the redirect PC. Sits between the stage units (IF/ID/EX/LSU/CSR) and all pipeline registers plus the PC generator.

## Interface
- `WDT_LIMIT`, 1024, consecutive `stallreq_mem_i` cycles before `timeout_o`; legal 1..65535.
- `clk_i` in 1: core clock.
- `n_rst_i` in 1: asynchronous, active-low reset.
- `stallreq_if_i` in 1: fetch stall request.
- `stallreq_id_i` in 1: decode stall request (load-use).
- `stallreq_ex_i` in 1: execute stall request (multicycle ALU).
- `stallreq_mem_i` in 1: LSU bus access outstanding.
- `branch_redirect_i` in 1: EX resolved a taken branch or jump.
- `branch_target_i` in 32: branch target.
- `trap_req_i` in 1: exception or interrupt accepted at commit.
- `trap_vector_i` in 32: trap handler address.
- `mret_req_i` in 1: mret committed.
- `mepc_i` in 32: return address.
- `stall_o` out 6: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
- `flush_o` out 1: flush all pipeline registers.
- `redirect_o` out 1: PC generator loads `redirect_pc_o`.
- `redirect_pc_o` out 32: next fetch address.
- `timeout_o` out 1: LSU stall watchdog pulse.

## Operation
- FSM states: RUN, TRAP_WAIT, FLUSH. Reset state RUN.
- Stall encoding in RUN, highest priority first:
  - mem: `6'b011111`
  - ex: `6'b001111`
  - id: `6'b000111`
  - if: `6'b000011`
  - none: `6'b000000`
- Bit 5 is never set. A stage at Stop with the next stage at NoStop inserts a bubble.
- RUN with `trap_req_i` or `mret_req_i`:
  - `trap_req_i` wins over mret: latch `trap_vector_i`, otherwise latch `mepc_i`, into `pc_q`.
  - If `stallreq_mem_i` = 1: go to TRAP_WAIT; else go to FLUSH.
  - `branch_redirect_i` in the same cycle is dropped.
- RUN branch without a trap: `redirect_o` = `branch_redirect_i & ~stall_o[3]`, with `redirect_pc_o` = `branch_target_i` (combinational, same cycle). No flush.
- TRAP_WAIT:
  - `stall_o` = `6'b011111`. `redirect_o` = 0. New trap, mret and branch inputs are ignored; `pc_q` is held.
  - Leave to FLUSH in the cycle after `stallreq_mem_i` samples 0.
- FLUSH (exactly one cycle):
  - `flush_o` = 1, `redirect_o` = 1, `redirect_pc_o` = `pc_q`, `stall_o` = 0.
  - All request inputs are ignored. Next state is RUN.
- `flush_o` is a Moore output (state == FLUSH). `stall_o`, `redirect_o` and `redirect_pc_o` are combinational from state and inputs.
- `redirect_pc_o` = 0 whenever `redirect_o` = 0.
- Reset values:
  - `stall_o` = 0, `flush_o` = 0, `redirect_o` = 0, `redirect_pc_o` = 0, `timeout_o` = 0.
  - `pc_q` = 0, watchdog counter = 0.
- Reset asserted mid-TRAP_WAIT or mid-FLUSH discards the pending trap immediately.

## Timing
- Trap in RUN with no mem stall: `flush_o` rises at the next clock edge, so latency is 1 cycle.
- Trap in RUN during a mem stall that drops after N further cycles: FLUSH is entered N+1 edges later.
- Back-to-back trap: one that arrives in the FLUSH cycle is lost. Upstream re-raises it from the restarted pipeline.
- Watchdog counter is 16 bits:
  - Increments on each edge with `stallreq_mem_i` = 1, saturating at `WDT_LIMIT`.
  - Clears to 0 on an edge with `stallreq_mem_i` = 0.
  - `timeout_o` is registered and pulses high for one cycle on the edge where the counter goes from `WDT_LIMIT`-1 to `WDT_LIMIT`.
  - No further pulse until the counter clears.

## Configuration
- `PIPE_CTRL_WDT_EN` defined: watchdog counter and `timeout_o` present as above.
- Undefined: no counter is built, `timeout_o` is tied to 0, and `WDT_LIMIT` is unused.

## Test plan
- Stall priority: assert `stallreq_if_i` + `stallreq_ex_i` → `stall_o` = `6'b001111`. Add `stallreq_mem_i` → `6'b011111`. Release all → `6'b000000`.
- Branch: `branch_redirect_i` = 1, target `0x0000_0120`, no stalls → same cycle `redirect_o` = 1, `redirect_pc_o` = `0x120`, `flush_o` = 0. Repeat with `stallreq_ex_i` = 1 → `redirect_o` = 0.
- Trap, no stall: `trap_req_i` + `mret_req_i` together, vector `0x8000_0004`, mepc `0x200` → next cycle `flush_o` = 1, `redirect_pc_o` = `0x8000_0004`, `stall_o` = 0; following cycle `flush_o` = 0.
- Trap during mem stall: `stallreq_mem_i` high for 5 cycles after a trap at cycle 0 → `stall_o` = `6'b011111` in cycles 1-5. `flush_o` = 1 exactly in cycle 6 with the latched vector. A branch pulse in cycle 3 is ignored.
- Watchdog (`PIPE_CTRL_WDT_EN`, `WDT_LIMIT` = 4): `stallreq_mem_i` held 10 cycles → a single one-cycle `timeout_o` pulse after the 4th high edge. Drop for 1 cycle, reassert for 4 → a second pulse.
- Reset: assert `n_rst_i` = 0 during TRAP_WAIT → all outputs 0 asynchronously. After release, the state is RUN and no flush occurs.
